// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte requesters
//
// Purpose:
//   NUM_REQ requesters each present a byte and hold req high until req_ack.
//   The arbiter grants one requester at a time in round-robin order, hands
//   the byte to the transmitter with a single-cycle tx_valid, waits for the
//   frame to finish (or for the watchdog to expire), acks the winner and
//   only re-arbitrates once the transmitter has gone fully idle.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   req          in   [NUM_REQ]    per-requester request level
//   req_data     in   [8*NUM_REQ]  byte for requester i on [8i+7:8i]
//   req_ack      out  [NUM_REQ]    one-cycle pulse to the served requester
//   grant_id     out  [GW]         current/last granted requester
//   busy         out  high in every state except IDLE
//   tx_data      out  [8]          byte to transmitter, registered at grant
//   tx_valid     out  one-cycle start pulse to transmitter
//   tx_active    in   transmitter is shifting a frame
//   tx_complete  in   transmitter frame done (2-cycle pulse)
//   timeout_err  out  one-cycle pulse when the watchdog aborts a frame

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLOCKS_PER_BIT = 520,
  parameter int TIMEOUT_CYCLES = 12 * CLOCKS_PER_BIT,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_active,
  input  logic                 tx_complete,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_SETTLE    = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);

  state_t               state_q,     state_d;
  logic [GW-1:0]        grant_q,     grant_d;
  logic [GW-1:0]        last_q,      last_d;
  logic [7:0]           tx_data_q,   tx_data_d;
  logic                 tx_valid_q,  tx_valid_d;
  logic [NUM_REQ-1:0]   ack_q,       ack_d;
  logic                 tmo_q,       tmo_d;
  logic [WW-1:0]        wd_q,        wd_d;

  logic                 sel_found;
  logic [GW-1:0]        sel_id;
  logic [WW-1:0]        wd_inc;

  // Round-robin pick: scan upward starting just past the last served
  // requester, so the one served most recently is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!sel_found && req[(int'(last_q) + off) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_id    = GW'((int'(last_q) + off) % NUM_REQ);
      end
    end
  end

  // Watchdog saturates so a stuck count can never wrap back under the limit.
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    ack_d      = '0;
    tmo_d      = 1'b0;
    wd_d       = wd_q;

    case (state_q)
      // The transmitter has no reset; wait out any frame left over from
      // before our reset, including its completion pulse.
      S_SETTLE: begin
        if (!tx_active && !tx_complete) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (sel_found) begin
          grant_d    = sel_id;
          tx_data_d  = req_data[8*sel_id +: 8];
          tx_valid_d = 1'b1;
          wd_d       = '0;
          state_d    = S_ISSUE;
        end
      end

      // The issue cycle counts as the first watchdog cycle, so the abort
      // lands exactly TIMEOUT_CYCLES after tx_valid.
      S_ISSUE: begin
        wd_d    = wd_inc;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        wd_d = wd_inc;
        if (tx_complete) begin
          ack_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = S_GAP;
        end else if (wd_q >= WD_LIMIT) begin
          ack_d[grant_q] = 1'b1;
          tmo_d          = 1'b1;
          last_d         = grant_q;
          state_d        = S_GAP;
        end
      end

      // Let the second cycle of tx_complete and the transmitter's own
      // recovery pass before the next grant.
      S_GAP: begin
        if (!tx_complete && !tx_active) state_d = S_IDLE;
      end

      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_SETTLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_REQ - 1);
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_q      <= '0;
      tmo_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
      wd_q       <= wd_d;
    end
  end

  assign req_ack     = ack_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign timeout_err = tmo_q;

endmodule
